// File: rtl/bmc_tx_pkg.sv
// Shared definitions for the biphase-mark transmitter.
// Contents:
//   state_e      - transmitter FSM states (IDLE, PRE, DATA)
//   DEF_*        - default parameter values used by the modules
//   cell_cycles  - clk cycles per full bit cell (2*HALF_BIT)
//   cnt_width    - width of the in-cell cycle counter
//   bit_width    - width of the cell (bit) counter
package bmc_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    DATA
  } state_e;

  localparam int unsigned DEF_HALF_BIT      = 16;
  localparam int unsigned DEF_DATA_W        = 8;
  localparam int unsigned DEF_PREAMBLE_BITS = 8;

  function automatic int unsigned cell_cycles(input int unsigned half_bit);
    return 2 * half_bit;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned half_bit);
    return $clog2(2 * half_bit);
  endfunction

  function automatic int unsigned bit_width(input int unsigned preamble_bits,
                                            input int unsigned data_w);
    return $clog2(((preamble_bits > data_w) ? preamble_bits : data_w) + 1);
  endfunction

endpackage

// File: rtl/bmc_cell_timer.sv
// In-cell cycle counter for the BMC transmitter.
// Counts 0..2*HALF_BIT-1 while running and wraps to 0.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   i_start       - synchronous load to 0 (frame start)
//   i_clear       - synchronous clear to 0 (frame end)
//   i_run         - advance the counter
//   o_cell_start  - running and the next cycle is the first of a new cell
//   o_mid_cell    - running and the next cycle is cell start + HALF_BIT
//   o_last_cycle  - counter is at its terminal value
module bmc_cell_timer
  import bmc_tx_pkg::*;
#(
  parameter int unsigned HALF_BIT = DEF_HALF_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  input  logic i_clear,
  input  logic i_run,
  output logic o_cell_start,
  output logic o_mid_cell,
  output logic o_last_cycle
);

  localparam int unsigned CELL_CYCLES = cell_cycles(HALF_BIT);
  localparam int unsigned CW          = cnt_width(HALF_BIT);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == CW'(CELL_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_start || i_clear) begin
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= w_last ? '0 : r_cnt + CW'(1);
    end
  end

  // Both pulses look one cycle ahead so the registered line level in the
  // top module changes exactly on count 0 / count HALF_BIT.
  assign o_last_cycle = w_last;
  assign o_cell_start = i_run && w_last;
  assign o_mid_cell   = i_run && (r_cnt == CW'(HALF_BIT - 1));

endmodule

// File: rtl/bmc_edge_tx.sv
// Biphase-mark line-code transmitter.
// Accepts words over valid/ready, sends PREAMBLE_BITS '0' cells at the start
// of a frame, then each word LSB first. Every cell toggles at its start; a '1'
// cell toggles again HALF_BIT cycles later. Back-to-back words continue the
// frame without a new preamble.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   s_data      - word to transmit (DATA_W bits)
//   s_valid     - s_data valid
//   s_ready     - word accepted this cycle when s_valid is also high
//   code_out    - BMC line level
//   code_edge   - one-cycle pulse in the cycle code_out shows a new value
//   busy        - high in PRE and DATA
module bmc_edge_tx
  import bmc_tx_pkg::*;
#(
  parameter int unsigned HALF_BIT      = DEF_HALF_BIT,
  parameter int unsigned DATA_W        = DEF_DATA_W,
  parameter int unsigned PREAMBLE_BITS = DEF_PREAMBLE_BITS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              code_out,
  output logic              code_edge,
  output logic              busy
);

  localparam int unsigned BW = bit_width(PREAMBLE_BITS, DATA_W);

  state_e            r_state;
  logic [DATA_W-1:0] r_shift;
  logic [BW-1:0]     r_bit;
  logic              r_code;
  logic              r_edge;

  logic w_cell_start;
  logic w_mid_cell;
  logic w_last_cycle;
  logic w_ready;
  logic w_accept;
  logic w_last_pre;
  logic w_last_data;
  logic w_start;
  logic w_clear;

  assign w_last_pre  = (r_bit == BW'(PREAMBLE_BITS - 1));
  assign w_last_data = (r_bit == BW'(DATA_W - 1));

  assign w_ready  = (r_state == IDLE) ||
                    ((r_state == DATA) && w_last_cycle && w_last_data);
  assign w_accept = s_valid && w_ready;

  assign w_start = (r_state == IDLE) && w_accept;
  assign w_clear = (r_state == DATA) && w_last_cycle && w_last_data && !w_accept;

  bmc_cell_timer #(
    .HALF_BIT (HALF_BIT)
  ) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (w_start),
    .i_clear      (w_clear),
    .i_run        (r_state != IDLE),
    .o_cell_start (w_cell_start),
    .o_mid_cell   (w_mid_cell),
    .o_last_cycle (w_last_cycle)
  );

  // Every assignment to r_code sits in the cycle before the level must show,
  // so r_edge set alongside it lines up with the new level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_code  <= 1'b0;
      r_edge  <= 1'b0;
    end else begin
      r_edge <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= PRE;
            r_bit   <= '0;
            r_shift <= s_data;
            r_code  <= ~r_code;
            r_edge  <= 1'b1;
          end
        end
        PRE: begin
          if (w_cell_start) begin
            r_code <= ~r_code;
            r_edge <= 1'b1;
            if (w_last_pre) begin
              r_state <= DATA;
              r_bit   <= '0;
            end else begin
              r_bit <= r_bit + BW'(1);
            end
          end
        end
        DATA: begin
          if (w_cell_start) begin
            if (w_last_data) begin
              r_bit <= '0;
              if (w_accept) begin
                r_shift <= s_data;
                r_code  <= ~r_code;
                r_edge  <= 1'b1;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_bit   <= r_bit + BW'(1);
              r_shift <= r_shift >> 1;
              r_code  <= ~r_code;
              r_edge  <= 1'b1;
            end
          end else if (w_mid_cell && r_shift[0]) begin
            r_code <= ~r_code;
            r_edge <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_ready   = w_ready;
  assign code_out  = r_code;
  assign code_edge = r_edge;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_bmc_edge_tx.sv
// Directed bench for bmc_edge_tx with HALF_BIT=4, PREAMBLE_BITS=4, DATA_W=8.
// Cycle index: cyc counts rising edges; "cycle T" is the interval after the
// T-th rising edge. Cell k of a frame accepted in cycle T starts at T+1+8k.
module tb_bmc_edge_tx;

  localparam int unsigned HB = 4;
  localparam int unsigned PB = 4;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          code_out;
  logic          code_edge;
  logic          busy;

  bmc_edge_tx #(
    .HALF_BIT      (HB),
    .DATA_W        (DW),
    .PREAMBLE_BITS (PB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .code_out  (code_out),
    .code_edge (code_edge),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int edges[$];
  always @(negedge clk) if (code_edge === 1'b1) edges.push_back(cyc);

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) step();
  endtask

  function automatic int edge_at(input int i);
    if (i < edges.size()) return edges[i];
    return -1000;
  endfunction

  int T, U, A, maxp, e;
  int exp1[16] = '{1, 9, 17, 25, 33, 37, 41, 49, 53, 57, 65, 73, 77, 81, 89, 93};
  logic [DW-1:0] w3c = 8'h3C;

  initial begin
    // ---------------- reset state ----------------
    step(); step();
    chk("rst_code_out", code_out, 0);
    chk("rst_code_edge", code_edge, 0);
    chk("rst_busy", busy, 0);
    chk("rst_s_ready", s_ready, 1);
    rst_n = 1'b1;
    step(); step();

    // ---------------- single word 0xA5 ----------------
    s_data = 8'hA5; s_valid = 1'b1;
    chk("t1_ready_idle", s_ready, 1);
    T = cyc;
    edges.delete();
    step();
    s_valid = 1'b0;
    chk("t1_lat_edge", code_edge, 1);
    chk("t1_lat_code", code_out, 1);
    chk("t1_busy", busy, 1);
    chk("t1_ready_pre", s_ready, 0);
    wait_to(T + 96);
    chk("t1_busy_last", busy, 1);
    step();
    chk("t1_busy_idle", busy, 0);
    chk("t1_ready_idle2", s_ready, 1);
    chk("t1_level_idle", code_out, 0);
    wait_to(T + 110);
    chk("t1_level_hold", code_out, 0);
    chk("t1_n_edges", edges.size(), 16);
    for (int i = 0; i < 16; i++)
      chk($sformatf("t1_edge%0d", i), edge_at(i) - T, exp1[i]);
    // max-period monitor: counts cycles between edges, max = CELL-1
    maxp = 0;
    for (int i = 0; i + 1 < 16; i++) begin
      e = edge_at(i + 1) - edge_at(i) - 1;
      if (e > maxp) maxp = e;
    end
    chk("t1_max_period", maxp, 2 * HB - 1);

    // ---------------- back-to-back 0xFF, 0x00 ----------------
    edges.delete();
    s_data = 8'hFF; s_valid = 1'b1;
    chk("t2_ready_idle", s_ready, 1);
    T = cyc;
    step();
    s_data = 8'h00;
    chk("t2_ready_pre", s_ready, 0);
    wait_to(T + 95);
    chk("t2_ready_early", s_ready, 0);
    step();
    chk("t2_ready_last", s_ready, 1);
    step();
    s_valid = 1'b0;
    chk("t2_edge_word2", code_edge, 1);
    chk("t2_busy_word2", busy, 1);
    wait_to(T + 170);
    chk("t2_n_edges", edges.size(), 28);
    for (int i = 0; i < 28; i++) begin
      if (i < 4)       e = 1 + 8 * i;
      else if (i < 20) e = 33 + 4 * (i - 4);
      else             e = 97 + 8 * (i - 20);
      chk($sformatf("t2_edge%0d", i), edge_at(i) - T, e);
    end
    chk("t2_busy_end", busy, 0);
    chk("t2_level_end", code_out, 0);

    // ---------------- backpressure with 0x3C ----------------
    s_data = 8'hC3; s_valid = 1'b1;
    chk("t3_ready_idle", s_ready, 1);
    T = cyc;
    step();
    s_data = 8'h3C;
    chk("t3_ready_p1", s_ready, 0);
    wait_to(T + 10);
    chk("t3_ready_p10", s_ready, 0);
    wait_to(T + 50);
    chk("t3_ready_d50", s_ready, 0);
    wait_to(T + 95);
    chk("t3_ready_d95", s_ready, 0);
    step();
    chk("t3_ready_d96", s_ready, 1);
    A = cyc;
    step();
    s_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      wait_to(A + 1 + 8 * k);
      chk($sformatf("t3_start%0d", k), code_edge, 1);
      wait_to(A + 5 + 8 * k);
      chk($sformatf("t3_mid%0d", k), code_edge, {31'b0, w3c[k]});
    end
    wait_to(A + 66);
    chk("t3_busy_end", busy, 0);

    // ---------------- reset mid-word, then 0x01 ----------------
    s_data = 8'hFF; s_valid = 1'b1;
    chk("t4_ready_idle", s_ready, 1);
    T = cyc;
    step();
    s_valid = 1'b0;
    wait_to(T + 57);
    chk("t4_bit3_edge", code_edge, 1);
    chk("t4_bit3_code", code_out, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t4_rst_code", code_out, 0);
    chk("t4_rst_edge", code_edge, 0);
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_ready", s_ready, 1);
    step();
    rst_n = 1'b1;
    step(); step();
    s_data = 8'h01; s_valid = 1'b1;
    chk("t4_ready_new", s_ready, 1);
    U = cyc;
    step();
    s_valid = 1'b0;
    chk("t4_lat_edge", code_edge, 1);
    chk("t4_lat_code", code_out, 1);
    wait_to(U + 5);  chk("t4_pre0_mid", code_edge, 0);
    wait_to(U + 9);  chk("t4_pre1", code_edge, 1);
    wait_to(U + 25); chk("t4_pre3", code_edge, 1);
    wait_to(U + 29); chk("t4_pre3_mid", code_edge, 0);
    wait_to(U + 33); chk("t4_bit0", code_edge, 1);
    wait_to(U + 37); chk("t4_bit0_mid", code_edge, 1);
    wait_to(U + 41); chk("t4_bit1", code_edge, 1);
    wait_to(U + 45); chk("t4_bit1_mid", code_edge, 0);
    wait_to(U + 100);
    chk("t4_busy_end", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
